scan_decoder: RTL and testbench
===============================

# scan_decoder

Parametrised active-low one-hot decoder with registered outputs and an auto-scan mode. It is the successor of the 3-to-8 decoder. It keeps the three-input enable gate (G1, G2A_L, G2B_L) and generalises the select width and the output count. It adds an internal scan sequencer that steps through outputs at a programmable rate for multiplexed digit/LED drive. The block sits between the display controller and the digit-select pins.

## Interface
Parameters:
- SEL_W, 3, select/index width.
- N_OUT, 8, number of outputs; 2 ≤ N_OUT ≤ 2^SEL_W.
- DIV, 4, enabled clocks per scan step; DIV ≥ 1.

Ports:
- CLK  in  1  clock, rising edge.
- RST_L  in  1  reset; asynchronous, active-low.
- G1  in  1  enable, active-high.
- G2A_L  in  1  enable, active-low.
- G2B_L  in  1  enable, active-low.
- MODE  in  1  0 = direct decode of SEL, 1 = auto-scan.
- SEL  in  SEL_W  select value, used in direct mode only.
- Y_L  out  N_OUT  registered decode, active-low one-hot.
- IDX  out  SEL_W  registered index currently driven.
- WRAP  out  1  one-cycle pulse when the scan index wraps from N_OUT-1 to 0.

## Operation
- Enable: EN = G1 & ~G2A_L & ~G2B_L, sampled each rising edge.
- Reset (RST_L low, asynchronous): Y_L = all ones, IDX = 0, WRAP = 0, prescaler = 0, state = DIRECT. All state is held while RST_L is low. Release takes effect on the first edge with RST_L high.
- States: DIRECT, SCAN. MODE is sampled at each edge.
  - MODE=0 → next state DIRECT.
  - MODE=1 in DIRECT → next state SCAN. On this entry edge, IDX and prescaler are loaded with 0.
  - MODE=1 in SCAN → stay in SCAN.
- DIRECT mode, per edge:
  - If EN and SEL < N_OUT: IDX ← SEL, Y_L ← ~(1 << SEL).
  - Else: Y_L ← all ones and IDX holds.
  - Prescaler ← 0; WRAP ← 0.
- SCAN mode, per edge, EN=1:
  - Prescaler counts 0..DIV-1.
  - When prescaler = DIV-1: prescaler ← 0 and IDX advances. IDX = N_OUT-1 wraps to 0 with WRAP ← 1 for that cycle. Any other IDX increments by 1.
  - Otherwise prescaler increments.
  - Y_L ← ~(1 << new IDX).
- SCAN mode, per edge, EN=0: prescaler and IDX freeze; Y_L ← all ones; WRAP ← 0. Scan resumes from the frozen count when EN returns.
- Entry edge into SCAN: IDX=0, prescaler=0. Y_L ← ~1 if EN, else all ones. WRAP=0.
- Invariants:
  - Y_L has at most one zero bit, and that bit is bit IDX.
  - Bits ≥ N_OUT do not exist.
  - IDX never reaches N_OUT.
- Arithmetic:
  - Prescaler width is clog2(DIV), minimum 1 bit.
  - IDX compare and wrap are done at SEL_W bits, with no reliance on natural overflow unless N_OUT = 2^SEL_W.
- Simultaneous events:
  - MODE falling on the same edge as a scheduled wrap: DIRECT wins, WRAP = 0.
  - EN dropping on a step edge: freeze wins, with no advance.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Direct latency: 1 clock from SEL/enable change to Y_L/IDX.
- Scan: with EN held high, IDX holds each value for exactly DIV clocks.
  - A full cycle is N_OUT·DIV clocks.
  - WRAP is high for 1 clock out of every N_OUT·DIV.
  - DIV=1 advances every clock.
- Mode change takes effect 1 clock after MODE is sampled.
- Reset mid-scan forces outputs immediately, without waiting for a clock edge.

## Test plan
- Reset: assert RST_L low mid-cycle with MODE=1, EN=1 → Y_L=8'hFF, IDX=0, WRAP=0 asynchronously. After release and MODE=0, SEL=5, EN=1 → next edge Y_L=8'hDF, IDX=5.
- Direct sweep, defaults: SEL 0..7 with G1=1, G2A_L=0, G2B_L=0 → Y_L=FE,FD,FB,F7,EF,DF,BF,7F, each 1 clock later. Each of G1=0, G2A_L=1, G2B_L=1 → FF with IDX held.
- Out-of-range, N_OUT=6, SEL_W=3: SEL=6 or 7 → Y_L=6'h3F with IDX unchanged. SEL=5 → 6'h1F.
- Scan timing, defaults (DIV=4): MODE 0→1 with EN=1 → IDX=0 for 4 clocks, then 1..7, 4 clocks each. IDX 7→0 at clock 32 with WRAP high exactly that cycle. Y_L tracks ~(1<<IDX).
- Freeze/resume: during scan at IDX=3 with prescaler=2, drop G1 for 5 clocks → Y_L=FF, IDX=3. Restore G1 → IDX=3 for 1 more clock, then 4.
- Mode collisions, DIV=1: MODE 1→0 on the edge where IDX would wrap 7→0 → WRAP stays 0 and Y_L follows SEL. Back to MODE=1 → IDX restarts at 0.

Source files
------------

// File: rtl/scan_decoder.sv
// Active-low one-hot digit-select decoder with a three-input enable gate,
// registered outputs and an auto-scan sequencer for multiplexed display drive.
module scan_decoder #(
   parameter int SEL_W = 3,
   parameter int N_OUT = 8,
   parameter int DIV   = 4
) (
   input  logic             CLK,
   input  logic             RST_L,
   input  logic             G1,
   input  logic             G2A_L,
   input  logic             G2B_L,
   input  logic             MODE,
   input  logic [SEL_W-1:0] SEL,
   output logic [N_OUT-1:0] Y_L,
   output logic [SEL_W-1:0] IDX,
   output logic             WRAP
);

   localparam int               PRE_W    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
   localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(N_OUT - 1);
   localparam logic [N_OUT-1:0] ALL_OFF  = '1;

   typedef enum logic {
      ST_DIRECT = 1'b0,
      ST_SCAN   = 1'b1
   } state_t;

   function automatic logic [N_OUT-1:0] decode_l(input logic [SEL_W-1:0] i);
      logic [N_OUT-1:0] r;
      r = ALL_OFF;
      for (int k = 0; k < N_OUT; k++) begin
         if (32'(i) == 32'(k)) r[k] = 1'b0;
      end
      return r;
   endfunction

   // Out-of-range selects blank the outputs rather than aliasing onto a pin.
   function automatic logic sel_in_range(input logic [SEL_W-1:0] s);
      return 32'(s) < 32'(N_OUT);
   endfunction

   function automatic logic [SEL_W-1:0] idx_step(input logic [SEL_W-1:0] i);
      return (i == IDX_LAST) ? '0 : i + SEL_W'(1);
   endfunction

   state_t           state_p0, state_nx;
   logic [PRE_W-1:0] presc_p0, presc_nx;
   logic [SEL_W-1:0] idx_p0,   idx_nx;
   logic [N_OUT-1:0] y_l_p0,   y_l_nx;
   logic             wrap_p0,  wrap_nx;
   logic             en;

   assign en = G1 & ~G2A_L & ~G2B_L;

   // Stage p0: next-state and next-output decision from the sampled inputs.
   always_comb begin
      state_nx = state_p0;
      presc_nx = presc_p0;
      idx_nx   = idx_p0;
      y_l_nx   = ALL_OFF;
      wrap_nx  = 1'b0;

      if (!MODE) begin
         state_nx = ST_DIRECT;
         presc_nx = '0;
         if (en && sel_in_range(SEL)) begin
            idx_nx = SEL;
            y_l_nx = decode_l(SEL);
         end
      end else if (state_p0 == ST_DIRECT) begin
         state_nx = ST_SCAN;
         presc_nx = '0;
         idx_nx   = '0;
         if (en) y_l_nx = decode_l('0);
      end else if (en) begin
         if (presc_p0 == PRE_LAST) begin
            presc_nx = '0;
            idx_nx   = idx_step(idx_p0);
            wrap_nx  = (idx_p0 == IDX_LAST);
         end else begin
            presc_nx = presc_p0 + PRE_W'(1);
         end
         y_l_nx = decode_l(idx_nx);
      end
   end

   always_ff @(posedge CLK or negedge RST_L) begin
      if (!RST_L) begin
         state_p0 <= ST_DIRECT;
         presc_p0 <= '0;
         idx_p0   <= '0;
         y_l_p0   <= ALL_OFF;
         wrap_p0  <= 1'b0;
      end else begin
         state_p0 <= state_nx;
         presc_p0 <= presc_nx;
         idx_p0   <= idx_nx;
         y_l_p0   <= y_l_nx;
         wrap_p0  <= wrap_nx;
      end
   end

   assign Y_L  = y_l_p0;
   assign IDX  = idx_p0;
   assign WRAP = wrap_p0;

endmodule

// File: tb/tb_scan_decoder.sv
// Bench for scan_decoder: three configurations share one stimulus stream and are
// compared every cycle against a tick-counting reference model.
module tb_scan_decoder;

   logic       CLK   = 1'b0;
   logic       RST_L = 1'b1;
   logic       G1    = 1'b0;
   logic       G2A_L = 1'b1;
   logic       G2B_L = 1'b1;
   logic       MODE  = 1'b0;
   logic [2:0] SEL   = 3'd0;

   logic [7:0] y0, y2;
   logic [5:0] y1;
   logic [2:0] i0, i1, i2;
   logic       w0, w1, w2;

   always #5 CLK = ~CLK;

   scan_decoder #(.SEL_W(3), .N_OUT(8), .DIV(4)) u0 (
      .CLK(CLK), .RST_L(RST_L), .G1(G1), .G2A_L(G2A_L), .G2B_L(G2B_L),
      .MODE(MODE), .SEL(SEL), .Y_L(y0), .IDX(i0), .WRAP(w0));
   scan_decoder #(.SEL_W(3), .N_OUT(6), .DIV(2)) u1 (
      .CLK(CLK), .RST_L(RST_L), .G1(G1), .G2A_L(G2A_L), .G2B_L(G2B_L),
      .MODE(MODE), .SEL(SEL), .Y_L(y1), .IDX(i1), .WRAP(w1));
   scan_decoder #(.SEL_W(3), .N_OUT(8), .DIV(1)) u2 (
      .CLK(CLK), .RST_L(RST_L), .G1(G1), .G2A_L(G2A_L), .G2B_L(G2B_L),
      .MODE(MODE), .SEL(SEL), .Y_L(y2), .IDX(i2), .WRAP(w2));

   int vectors     = 0;
   int miscompares = 0;

   int n_out [3] = '{8, 6, 8};
   int div_n [3] = '{4, 2, 1};
   bit m_scan[3];
   int m_tick[3];
   int m_idx [3];
   int m_y   [3];
   int m_wrap[3];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int ones(input int k);
      return (1 << n_out[k]) - 1;
   endfunction

   function automatic logic [31:0] dut_y(input int k);
      case (k)
         0:       return 32'(y0);
         1:       return 32'(y1);
         default: return 32'(y2);
      endcase
   endfunction

   function automatic logic [31:0] dut_i(input int k);
      case (k)
         0:       return 32'(i0);
         1:       return 32'(i1);
         default: return 32'(i2);
      endcase
   endfunction

   function automatic logic [31:0] dut_w(input int k);
      case (k)
         0:       return 32'(w0);
         1:       return 32'(w1);
         default: return 32'(w2);
      endcase
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_scan[k] = 1'b0;
         m_tick[k] = 0;
         m_idx[k]  = 0;
         m_y[k]    = ones(k);
         m_wrap[k] = 0;
      end
   endtask

   // Scan position is a single tick count: index = tick / DIV, modulo one full cycle.
   task automatic model_edge();
      bit en;
      int s;
      en = G1 && !G2A_L && !G2B_L;
      s  = int'(SEL);
      for (int k = 0; k < 3; k++) begin
         m_wrap[k] = 0;
         if (!MODE) begin
            m_scan[k] = 1'b0;
            if (en && s < n_out[k]) begin
               m_idx[k] = s;
               m_y[k]   = ones(k) & ~(1 << s);
            end else begin
               m_y[k] = ones(k);
            end
         end else if (!m_scan[k]) begin
            m_scan[k] = 1'b1;
            m_tick[k] = 0;
            m_idx[k]  = 0;
            m_y[k]    = en ? (ones(k) & ~1) : ones(k);
         end else if (en) begin
            m_tick[k] = (m_tick[k] + 1) % (n_out[k] * div_n[k]);
            m_idx[k]  = m_tick[k] / div_n[k];
            m_wrap[k] = (m_tick[k] == 0) ? 1 : 0;
            m_y[k]    = ones(k) & ~(1 << m_idx[k]);
         end else begin
            m_y[k] = ones(k);
         end
      end
   endtask

   task automatic check_all(input string phase);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("%s.u%0d.y_l", phase, k), dut_y(k), 32'(m_y[k]));
         check($sformatf("%s.u%0d.idx", phase, k), dut_i(k), 32'(m_idx[k]));
         check($sformatf("%s.u%0d.wrap", phase, k), dut_w(k), 32'(m_wrap[k]));
      end
   endtask

   // Called at a falling edge with inputs already driven.
   task automatic cycle(input string phase);
      @(posedge CLK);
      model_edge();
      @(negedge CLK);
      check_all(phase);
   endtask

   task automatic set_en(input bit on);
      G1    = on;
      G2A_L = 1'b0;
      G2B_L = 1'b0;
   endtask

   initial begin
      int wr[3];
      logic [7:0] e;

      #1 RST_L = 1'b0;
      model_reset();
      MODE = 1'b1;
      set_en(1'b1);
      repeat (2) @(negedge CLK);
      check("rst.y0", 32'(y0), 32'hFF);
      check("rst.idx0", 32'(i0), 32'd0);
      check("rst.wrap0", 32'(w0), 32'd0);
      check_all("rst");

      RST_L = 1'b1;
      MODE  = 1'b0;
      SEL   = 3'd5;
      cycle("release");
      check("release.y0", 32'(y0), 32'hDF);
      check("release.idx0", 32'(i0), 32'd5);

      for (int s = 0; s < 8; s++) begin
         SEL = 3'(s);
         cycle("sweep");
         e = 8'hFF & ~(8'd1 << s);
         check("sweep.y0", 32'(y0), 32'(e));
         if (s >= 6) check("range.y1", 32'(y1), 32'h3F);
      end
      check("range.idx1", 32'(i1), 32'd5);

      SEL = 3'd2;
      cycle("gate");
      G1 = 1'b0;
      cycle("gate.g1");
      check("gate.g1.y0", 32'(y0), 32'hFF);
      check("gate.g1.idx0", 32'(i0), 32'd2);
      G1 = 1'b1; G2A_L = 1'b1;
      SEL = 3'd6;
      cycle("gate.g2a");
      G2A_L = 1'b0; G2B_L = 1'b1;
      cycle("gate.g2b");
      check("gate.g2b.idx0", 32'(i0), 32'd2);
      set_en(1'b1);

      wr = '{0, 0, 0};
      MODE = 1'b1;
      for (int c = 0; c < 40; c++) begin
         cycle("scan");
         wr[0] += int'(w0);
         wr[1] += int'(w1);
         wr[2] += int'(w2);
      end
      check("scan.wraps0", 32'(wr[0]), 32'd1);
      check("scan.wraps1", 32'(wr[1]), 32'd3);
      check("scan.wraps2", 32'(wr[2]), 32'd4);

      MODE = 1'b0;
      cycle("frz.exit");
      MODE = 1'b1;
      cycle("frz.entry");
      repeat (14) cycle("frz.run");
      check("frz.pre.idx0", 32'(i0), 32'd3);
      G1 = 1'b0;
      repeat (5) cycle("frz.hold");
      check("frz.hold.y0", 32'(y0), 32'hFF);
      check("frz.hold.idx0", 32'(i0), 32'd3);
      G1 = 1'b1;
      cycle("frz.resume");
      check("frz.resume.idx0", 32'(i0), 32'd3);
      cycle("frz.step");
      check("frz.step.idx0", 32'(i0), 32'd4);
      check("frz.step.y0", 32'(y0), 32'hEF);

      MODE = 1'b0;
      cycle("col.exit");
      MODE = 1'b1;
      cycle("col.entry");
      repeat (7) cycle("col.run");
      check("col.pre.idx2", 32'(i2), 32'd7);
      MODE = 1'b0;
      SEL  = 3'd4;
      cycle("col.edge");
      check("col.edge.wrap2", 32'(w2), 32'd0);
      check("col.edge.y2", 32'(y2), 32'hEF);
      MODE = 1'b1;
      cycle("col.back");
      check("col.back.idx2", 32'(i2), 32'd0);

      repeat (5) cycle("arst.run");
      @(posedge CLK);
      #2 RST_L = 1'b0;
      #1;
      model_reset();
      check("arst.y0", 32'(y0), 32'hFF);
      check("arst.idx0", 32'(i0), 32'd0);
      check_all("arst");
      @(posedge CLK);
      @(negedge CLK);
      check_all("arst.hold");
      RST_L = 1'b1;
      MODE  = 1'b0;
      cycle("arst.release");

      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(15) == 0) MODE = ~MODE;
         G1    = ($urandom_range(7) != 0);
         G2A_L = ($urandom_range(9) == 0);
         G2B_L = ($urandom_range(9) == 0);
         SEL   = 3'($urandom_range(7));
         cycle("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
